// File: rtl/matmul_seq_ctrl_if.sv
// Control bus between the matmul sequencer and the matrix multiplier top.
// master: sequencer side, slave: multiplier side.
interface matmul_seq_ctrl_if;
    logic       done;
    logic       en;
    logic       valid;
    logic [1:0] mode;
    logic       clear;
    logic       wr_temp_en;
    logic [2:0] wr_temp_addr;
    logic       rd_temp_en;
    logic [2:0] rd_temp_addr;

    modport master (
        output en, valid, mode, clear, wr_temp_en, wr_temp_addr, rd_temp_en, rd_temp_addr,
        input  done
    );

    modport slave (
        input  en, valid, mode, clear, wr_temp_en, wr_temp_addr, rd_temp_en, rd_temp_addr,
        output done
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the matrix multiplier: phase-1 operand passes into temp, phase-2 read-back.
// Define MMSEQ_TIMEOUT_EN to bound the wait for the datapath done (err_o on expiry).
module matmul_seq_ctrl #(
    parameter int unsigned N_BEAT      = 4,
    parameter int unsigned N_PASS      = 8,
    parameter int unsigned GAP         = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        op_pass_o,
    output logic [3:0]        op_beat_o,
    matmul_seq_ctrl_if.master mm
);

    // Index widths are fixed by the port list; refuse parameters that would overflow them.
    if (N_BEAT < 2 || N_BEAT > 15 || N_PASS < 2 || N_PASS > 8 || GAP < 1 || GAP > 7 ||
        TIMEOUT_CYC < 1) begin : gen_param_err
        $error("matmul_seq_ctrl: parameter out of range");
    end

    localparam logic [3:0] BeatLast = 4'(N_BEAT - 1);
    localparam logic [2:0] PassLast = 3'(N_PASS - 1);
    localparam logic [2:0] GapLast  = 3'(GAP - 1);

    typedef enum logic [2:0] {
        StIdle, StFeed, StGap, StWb, StPause, StRead, StWait, StDone
    } state_e;

    state_e     state_q;
    logic [2:0] gap_q;  // idle-cycle counter, shared by GAP and PAUSE

`ifdef MMSEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tmo_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q         <= StIdle;
            gap_q           <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            op_pass_o       <= '0;
            op_beat_o       <= '0;
            mm.en           <= 1'b0;
            mm.valid        <= 1'b0;
            mm.mode         <= 2'b00;
            mm.clear        <= 1'b0;
            mm.wr_temp_en   <= 1'b0;
            mm.wr_temp_addr <= '0;
            mm.rd_temp_en   <= 1'b0;
            mm.rd_temp_addr <= '0;
`ifdef MMSEQ_TIMEOUT_EN
            err_o           <= 1'b0;
            tmo_q           <= '0;
`endif
        end else begin
            // Strobes are single-cycle unless a state re-asserts them below.
            mm.en         <= 1'b0;
            mm.valid      <= 1'b0;
            mm.clear      <= 1'b0;
            mm.wr_temp_en <= 1'b0;
            mm.rd_temp_en <= 1'b0;
            done_o        <= 1'b0;
`ifdef MMSEQ_TIMEOUT_EN
            err_o         <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StFeed;
                        busy_o    <= 1'b1;
                        mm.mode   <= 2'b01;
                        mm.en     <= 1'b1;
                        op_pass_o <= '0;
                        op_beat_o <= '0;
                    end
                end
                StFeed: begin
                    if (op_beat_o == BeatLast) begin
                        state_q <= StGap;
                        gap_q   <= '0;
                        if (GapLast == 3'd0) mm.wr_temp_addr <= op_pass_o;
                    end else begin
                        op_beat_o <= op_beat_o + 4'd1;
                        mm.en     <= 1'b1;
                        mm.valid  <= (op_beat_o + 4'd1 == BeatLast);
                        mm.clear  <= (op_beat_o == 4'd0) && (op_pass_o != 3'd0);
                    end
                end
                StGap: begin
                    if (gap_q == GapLast) begin
                        // Result of the pass just fed is written during the next pass's beat 0.
                        mm.wr_temp_en <= 1'b1;
                        if (op_pass_o < PassLast) begin
                            state_q   <= StFeed;
                            op_pass_o <= op_pass_o + 3'd1;
                            op_beat_o <= '0;
                            mm.en     <= 1'b1;
                        end else begin
                            state_q <= StWb;
                        end
                    end else begin
                        gap_q <= gap_q + 3'd1;
                        if (gap_q + 3'd1 == GapLast) mm.wr_temp_addr <= op_pass_o;
                    end
                end
                StWb: begin
                    state_q <= StPause;
                    gap_q   <= '0;
                end
                StPause: begin
                    if (gap_q == 3'd1) begin
                        state_q         <= StRead;
                        mm.mode         <= 2'b10;
                        mm.en           <= 1'b1;
                        mm.rd_temp_en   <= 1'b1;
                        mm.rd_temp_addr <= '0;
                        op_pass_o       <= '0;
                        op_beat_o       <= '0;
                    end else begin
                        gap_q <= gap_q + 3'd1;
                    end
                end
                StRead: begin
                    if (op_pass_o == PassLast) begin
                        state_q <= StWait;
`ifdef MMSEQ_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end else begin
                        op_pass_o       <= op_pass_o + 3'd1;
                        mm.rd_temp_addr <= op_pass_o + 3'd1;
                        mm.en           <= 1'b1;
                        mm.rd_temp_en   <= 1'b1;
                        mm.clear        <= (op_pass_o == 3'd0);
                        mm.valid        <= (op_pass_o + 3'd1 == PassLast);
                    end
                end
                StWait: begin
                    // done wins over an expiring count on the same cycle
                    if (mm.done) begin
                        state_q <= StDone;
                        done_o  <= 1'b1;
                    end
`ifdef MMSEQ_TIMEOUT_EN
                    else if (tmo_q == TmoLast) begin
                        state_q <= StDone;
                        err_o   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
`endif
                end
                StDone: begin
                    state_q         <= StIdle;
                    busy_o          <= 1'b0;
                    mm.mode         <= 2'b00;
                    op_pass_o       <= '0;
                    op_beat_o       <= '0;
                    mm.wr_temp_addr <= '0;
                    mm.rd_temp_addr <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: cycle-indexed vector table plus multi-cycle sequences.
// Timeout expectations follow MMSEQ_TIMEOUT_EN as compiled.
module tb_matmul_seq_ctrl;
    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] op_pass;
    logic [3:0] op_beat;

    matmul_seq_ctrl_if mm_bus ();

    matmul_seq_ctrl #(
        .N_BEAT     (4),
        .N_PASS     (8),
        .GAP        (2),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .start_i  (start),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .op_pass_o(op_pass),
        .op_beat_o(op_beat),
        .mm       (mm_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       en;
        logic       valid;
        logic [1:0] mode;
        logic       clear;
        logic       wr_en;
        logic [2:0] wr_addr;
        logic       rd_en;
        logic [2:0] rd_addr;
        logic [2:0] pass;
        logic [3:0] beat;
    } outs_t;

    typedef struct {
        int    cyc;
        logic  mm_done;
        outs_t exp;
    } vec_t;

    vec_t vecs[$];

    function automatic outs_t o(int b, int d, int en, int v, int m, int cl, int we, int wa,
                                int re, int ra, int p, int bt);
        outs_t r;
        r.busy    = b[0];
        r.done    = d[0];
        r.err     = 1'b0;
        r.en      = en[0];
        r.valid   = v[0];
        r.mode    = m[1:0];
        r.clear   = cl[0];
        r.wr_en   = we[0];
        r.wr_addr = wa[2:0];
        r.rd_en   = re[0];
        r.rd_addr = ra[2:0];
        r.pass    = p[2:0];
        r.beat    = bt[3:0];
        return r;
    endfunction

    function automatic void add(int c, logic md, outs_t e);
        vec_t v;
        v.cyc     = c;
        v.mm_done = md;
        v.exp     = e;
        vecs.push_back(v);
    endfunction

    function automatic outs_t sample();
        outs_t r;
        r.busy    = busy;
        r.done    = done;
        r.err     = err;
        r.en      = mm_bus.en;
        r.valid   = mm_bus.valid;
        r.mode    = mm_bus.mode;
        r.clear   = mm_bus.clear;
        r.wr_en   = mm_bus.wr_temp_en;
        r.wr_addr = mm_bus.wr_temp_addr;
        r.rd_en   = mm_bus.rd_temp_en;
        r.rd_addr = mm_bus.rd_temp_addr;
        r.pass    = op_pass;
        r.beat    = op_beat;
        return r;
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (busy done err en valid mode clear wr_en wr_addr rd_en rd_addr pass beat)",
                     name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Strobe monitor for the full default run.
    logic mon_en  = 1'b0;
    logic mon_clr = 1'b0;
    int cyc_cnt, n_valid, n_wr, n_clr, n_en, n_rd, n_done, wr_bad, rd_bad, last_rd;

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mon_clr) begin
            n_valid <= 0; n_wr <= 0; n_clr <= 0; n_en <= 0; n_rd <= 0;
            n_done  <= 0; wr_bad <= 0; rd_bad <= 0; last_rd <= 0;
        end else if (mon_en) begin
            if (mm_bus.valid) n_valid <= n_valid + 1;
            if (mm_bus.clear) n_clr <= n_clr + 1;
            if (mm_bus.en) n_en <= n_en + 1;
            if (done) n_done <= n_done + 1;
            if (mm_bus.wr_temp_en) begin
                if (int'(mm_bus.wr_temp_addr) != n_wr) wr_bad <= wr_bad + 1;
                n_wr <= n_wr + 1;
            end
            if (mm_bus.rd_temp_en) begin
                if (int'(mm_bus.rd_temp_addr) != n_rd || mm_bus.mode != 2'b10)
                    rd_bad <= rd_bad + 1;
                else if (n_rd != 0 && cyc_cnt != last_rd + 1)
                    rd_bad <= rd_bad + 1;
                last_rd <= cyc_cnt;
                n_rd    <= n_rd + 1;
            end
        end
    end

    // Called at a negedge while idle; cycle 1 is the first FEED cycle.
    task automatic run_table(input int last_c);
        int idx = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            mm_bus.done = 1'b0;
            if (idx < vecs.size() && vecs[idx].cyc == c) begin
                check_outs($sformatf("vec_c%0d", c), vecs[idx].exp);
                mm_bus.done = vecs[idx].mm_done;
                idx++;
            end
            @(negedge clk);
        end
        mm_bus.done = 1'b0;
    endtask

`ifdef MMSEQ_TIMEOUT_EN
    localparam int TmoLastC = 80;
`else
    localparam int TmoLastC = 200;
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_cnt, done_cnt, extra, n_err, err_c, ok;
        rstn        = 1'b0;
        start       = 1'b0;
        mm_bus.done = 1'b0;

        // Mode 1 = 01 (phase 1), 2 = 10 (phase 2).
        add(1,  1'b0, o(1,0,1,0,1,0,0,0,0,0,0,0));
        add(2,  1'b0, o(1,0,1,0,1,0,0,0,0,0,0,1));
        add(4,  1'b0, o(1,0,1,1,1,0,0,0,0,0,0,3));
        add(5,  1'b0, o(1,0,0,0,1,0,0,0,0,0,0,3));
        add(7,  1'b0, o(1,0,1,0,1,0,1,0,0,0,1,0));
        add(8,  1'b0, o(1,0,1,0,1,1,0,0,0,0,1,1));
        add(10, 1'b1, o(1,0,1,1,1,0,0,0,0,0,1,3));
        add(11, 1'b0, o(1,0,0,0,1,0,0,0,0,0,1,3));
        add(12, 1'b0, o(1,0,0,0,1,0,0,1,0,0,1,3));
        add(13, 1'b0, o(1,0,1,0,1,0,1,1,0,0,2,0));
        add(46, 1'b0, o(1,0,1,1,1,0,0,6,0,0,7,3));
        add(48, 1'b0, o(1,0,0,0,1,0,0,7,0,0,7,3));
        add(49, 1'b0, o(1,0,0,0,1,0,1,7,0,0,7,3));
        add(51, 1'b0, o(1,0,0,0,1,0,0,7,0,0,7,3));
        add(52, 1'b0, o(1,0,1,0,2,0,0,7,1,0,0,0));
        add(53, 1'b0, o(1,0,1,0,2,1,0,7,1,1,1,0));
        add(59, 1'b0, o(1,0,1,1,2,0,0,7,1,7,7,0));
        add(60, 1'b0, o(1,0,0,0,2,0,0,7,0,7,7,0));
        add(63, 1'b1, o(1,0,0,0,2,0,0,7,0,7,7,0));
        add(64, 1'b0, o(1,1,0,0,2,0,0,7,0,7,7,0));
        add(65, 1'b0, o(0,0,0,0,0,0,0,0,0,0,0,0));

        repeat (2) @(negedge clk);
        check_outs("reset_state", '0);
        rstn = 1'b1;
        @(negedge clk);
        check_outs("idle_after_reset", '0);

        // Full default run, mm_done pulsed in FEED (c10) and in WAIT_DONE (c63).
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        mon_en  = 1'b1;
        run_table(66);
        mon_en = 1'b0;
        check_int("valid_count", n_valid, 9);
        check_int("wr_temp_count", n_wr, 8);
        check_int("clear_count", n_clr, 8);
        check_int("en_count", n_en, 40);
        check_int("rd_temp_count", n_rd, 8);
        check_int("done_count", n_done, 1);
        check_int("wr_addr_order", wr_bad, 0);
        check_int("rd_addr_order", rd_bad, 0);

        // Asynchronous reset at the 20th busy cycle, then an identical restart.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check_int("busy_before_reset", int'(busy), 1);
        rstn = 1'b0;
        #1;
        check_outs("async_reset_mid_run", '0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_table(13);
        rstn = 1'b0;
        #1;
        check_outs("reset_second_run", '0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // start and mm_done held high: back-to-back runs with one idle cycle between.
        idle_cnt = 0;
        done_cnt = 0;
        start       = 1'b1;
        mm_bus.done = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 124; c++) begin
            if (c == 61) check_int("held_done_c61", int'(done), 1);
            if (c == 62) check_outs("held_idle_c62", '0);
            if (c == 63) check_outs("held_restart_c63", o(1,0,1,0,1,0,0,0,0,0,0,0));
            if (!busy) idle_cnt++;
            if (done) done_cnt++;
            @(negedge clk);
        end
        check_int("held_idle_cycles", idle_cnt, 2);
        check_int("held_done_count", done_cnt, 2);
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check_int("held_final_return", ok, 1);
        mm_bus.done = 1'b0;
        @(negedge clk);

        // start pulses while busy (including the done cycle) must not queue a run.
        extra    = 0;
        done_cnt = 0;
        for (int c = 0; c <= 70; c++) begin
            if (c >= 62 && busy) extra++;
            if (done) done_cnt++;
            if (c == 61) check_int("pulse_done_c61", int'(done), 1);
            start       = (c == 0 || c == 5 || c == 30 || c == 61);
            mm_bus.done = (c == 60);
            @(negedge clk);
        end
        start       = 1'b0;
        mm_bus.done = 1'b0;
        check_int("pulse_no_extra_run", extra, 0);
        check_int("pulse_done_count", done_cnt, 1);

        // No mm_done at all.
        n_err    = 0;
        err_c    = 0;
        done_cnt = 0;
        for (int c = 0; c <= TmoLastC; c++) begin
            if (err) begin
                n_err++;
                err_c = c;
            end
            if (done) done_cnt++;
            start = (c == 0);
            @(negedge clk);
        end
        check_int("tmo_done_count", done_cnt, 0);
`ifdef MMSEQ_TIMEOUT_EN
        check_int("tmo_err_count", n_err, 1);
        check_int("tmo_err_cycle", err_c, 76);
        check_outs("tmo_back_idle", '0);
`else
        check_int("no_tmo_err_count", n_err, 0);
        check_int("no_tmo_still_busy", int'(busy), 1);
`endif
        rstn = 1'b0;
        #1;
        check_outs("final_reset", '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Control sequencer for the advanced matrix multiplier top.
- Replaces hand-written bench stimulus: drives en/valid/mode/clear/temp-buffer controls through phase 1 (mode 01, N_PASS passes of N_BEAT operand beats each, with each partial result written to temp) and phase 2 (mode 10, temp read-back accumulation), then waits for the datapath done.
- Emits pass/beat indices so an operand buffer can present din1/din2/din3 in step.

Parameters:
- N_BEAT, 4, operand beats per phase-1 pass (2..15)
- N_PASS, 8, phase-1 passes = temp entries = phase-2 beats (2..8)
- GAP, 2, idle cycles after each valid pulse (1..7)
- TIMEOUT_CYC, 64, done wait limit (used only with the optional feature)

Ports:
- clk_i, in, 1, clock
- rstn_i, in, 1, asynchronous active-low reset
- start_i, in, 1, start request; sampled only in IDLE
- busy_o, out, 1, high from the cycle after start is accepted until the return to IDLE
- done_o, out, 1, one-cycle pulse when the datapath done is seen
- err_o, out, 1, one-cycle pulse on timeout (0 without the optional feature)
- mm_done_i, in, 1, done_o from the multiplier top
- mm_en_o, out, 1, en_i to the top
- mm_valid_o, out, 1, valid_i to the top
- mm_mode_o, out, 2, mode: 00 idle, 01 phase 1, 10 phase 2
- mm_clear_o, out, 1, clear to the top
- mm_wr_temp_en_o, out, 1, temp write strobe
- mm_wr_temp_addr_o, out, 3, temp write address
- mm_rd_temp_en_o, out, 1, temp read enable
- mm_rd_temp_addr_o, out, 3, temp read address
- op_pass_o, out, 3, current pass index (phase 1) or read index (phase 2)
- op_beat_o, out, 4, current beat index within the pass

Behaviour:
- Reset: all outputs 0, state IDLE. Reset asserted mid-sequence aborts immediately; no partial done.
- All outputs are registered (Moore). Start sampled at edge T puts the first FEED cycle at T+1.
- States: IDLE, FEED, GAP, WB, PAUSE, READ, WAIT_DONE.
- IDLE:
  - start_i=1 -> FEED with pass=0, beat=0, mode=01.
  - start_i while busy is ignored (not queued).
- FEED (pass p, beat b):
  - en=1; op_pass=p; op_beat=b.
  - valid=1 only when b=N_BEAT-1.
  - wr_temp_en=1 only at b=0 with p>=1; writes result p-1 at wr_temp_addr=p-1.
  - clear=1 only at b=1 with p>=1.
  - b=N_BEAT-1 -> GAP.
- GAP: en=0, valid=0, for GAP cycles.
  - wr_temp_addr is updated to p on the last GAP cycle and held until the next write.
  - Then if p<N_PASS-1: p++ -> FEED. Otherwise -> WB.
- WB: one cycle, wr_temp_en=1, wr_temp_addr=N_PASS-1, en=0. -> PAUSE.
- PAUSE: 2 idle cycles; mode stays 01. -> READ with k=0.
- READ (k):
  - mode=10, en=1, rd_temp_en=1, rd_temp_addr=k, op_pass=k, op_beat=0.
  - clear=1 at k=1.
  - valid=1 at k=N_PASS-1, then -> WAIT_DONE.
- WAIT_DONE:
  - All strobes 0; mode held at 10.
  - mm_done_i=1 -> done_o pulse in the next cycle, with busy_o still high in that cycle; then IDLE with mode=00.
- mm_done_i outside WAIT_DONE is ignored.
- Indices wrap never: counters saturate at their terminal values and their width is checked against the parameters.
- Strobe counts per run:
  - valid: N_PASS+1
  - wr_temp_en: N_PASS
  - clear: N_PASS
  - en cycles: N_PASS*N_BEAT+N_PASS
- Defaults: start-accept to WAIT_DONE entry = 48+1+2+8 = 59 cycles.

Optional Feature:
- Macro MMSEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE.
  - If mm_done_i is not seen within TIMEOUT_CYC cycles: err_o pulses one cycle, no done_o, return to IDLE.
  - mm_done_i on the same cycle as the count expiring counts as success (done wins).
- Undefined: WAIT_DONE waits indefinitely; err_o tied to 0; no counter logic.

Test Plan:
- Reset then start at T -> en high T+1..T+4; valid at T+4 only; wr_temp_en at T+7 with addr 0; clear at T+8; op_pass=1 at T+7.
- Full run with defaults, mm_done_i raised 3 cycles after WAIT_DONE entry -> counts: 9 valid, 8 wr_temp_en (addr 0..7 in order), 8 clear; rd_temp_addr 0..7 on consecutive cycles with mode=10; done_o one pulse; busy_o falls after it.
- start_i held high through a whole run -> after IDLE a second run begins; start pulses during busy produce no extra run.
- rstn_i asserted at the 20th busy cycle -> all outputs 0 asynchronously; a restart gives the identical sequence from pass 0.
- mm_done_i pulsed during FEED -> ignored; done_o only after WAIT_DONE sees mm_done_i.
- With MMSEQ_TIMEOUT_EN and TIMEOUT_CYC=16, no mm_done_i -> err_o pulses 16 cycles after WAIT_DONE entry, done_o stays 0, return to IDLE; without the macro the block stays busy indefinitely.
